// File: rtl/frame_plotter.sv
// rtl/frame_plotter.sv - raster scan driver realigning renderer colors into framebuffer plots
module frame_plotter #(
    parameter int SCREEN_W       = 160,
    parameter int SCREEN_H       = 120,
    parameter int RENDER_LATENCY = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frameClk,
    output logic [7:0] x,
    output logic [7:0] y,
    input  logic [2:0] color_in,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_color,
    output logic       vga_plot,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] overrun_cnt
);
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);
    localparam logic [2:0] LAT    = 3'(RENDER_LATENCY);
    localparam int         LAST   = RENDER_LATENCY - 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic [2:0] cnt_q, cnt_d;
    logic       pending_q, pending_d;
    logic [7:0] ovr_q, ovr_d;
    logic       sync1_q, sync2_q, prev_q;
    logic       req;
    logic       issue_valid;

    logic [RENDER_LATENCY-1:0] pv_q;
    logic [7:0]                px_q [RENDER_LATENCY];
    logic [7:0]                py_q [RENDER_LATENCY];
    logic [7:0]                vga_x_q, vga_y_q;
    logic [2:0]                vga_color_q;
    logic                      vga_plot_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= frameClk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign req = sync2_q & ~prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            ovr_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        ovr_d     = ovr_q;
        case (state_q)
            IDLE: begin
                // A request landing on the one IDLE cycle of a pending start becomes the next pending frame
                if (req || pending_q) begin
                    state_d   = SCAN;
                    pending_d = req && pending_q;
                end
            end
            SCAN: begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        state_d = DRAIN;
                        cnt_d   = LAT;
                    end else begin
                        y_d = y_q + 8'd1;
                    end
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == 3'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
        if (req && state_q != IDLE) begin
            if (!pending_q)            pending_d = 1'b1;
            else if (ovr_q != 8'hFF)   ovr_d     = ovr_q + 8'd1;
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        issue_valid = (state_q == SCAN);
        frame_done  = (state_q == DRAIN) && (cnt_q == 3'd0);
    end

    // Coordinate delay line matching the renderer latency
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pv_q <= '0;
            for (int i = 0; i < RENDER_LATENCY; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= issue_valid;
            px_q[0] <= x_q;
            py_q[0] <= y_q;
            for (int i = 1; i < RENDER_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                px_q[i] <= px_q[i-1];
                py_q[i] <= py_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_plot_q  <= 1'b0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
        end else begin
            vga_plot_q <= pv_q[LAST];
            if (pv_q[LAST]) begin
                vga_x_q     <= px_q[LAST];
                vga_y_q     <= py_q[LAST];
                vga_color_q <= color_in;
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign overrun_cnt = ovr_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_color   = vga_color_q;
    assign vga_plot    = vga_plot_q;
endmodule

// File: tb/tb_frame_plotter.sv
// tb/tb_frame_plotter.sv - latency-2 and latency-4 plotters against a raster scoreboard
module tb_frame_plotter;
    logic clk = 1'b0;
    logic resetn, frameClk, clr;
    logic [7:0] x2, y2, vx2, vy2, oc2, x4, y4, vx4, vy4, oc4;
    logic [2:0] c2, vc2, c4, vc4;
    logic vp2, b2, fd2, vp4, b4, fd4;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_plotter #(.SCREEN_W(160), .SCREEN_H(120), .RENDER_LATENCY(2)) dut2 (
        .clk(clk), .resetn(resetn), .frameClk(frameClk), .x(x2), .y(y2), .color_in(c2),
        .vga_x(vx2), .vga_y(vy2), .vga_color(vc2), .vga_plot(vp2), .busy(b2),
        .frame_done(fd2), .overrun_cnt(oc2));

    frame_plotter #(.SCREEN_W(160), .SCREEN_H(120), .RENDER_LATENCY(4)) dut4 (
        .clk(clk), .resetn(resetn), .frameClk(frameClk), .x(x4), .y(y4), .color_in(c4),
        .vga_x(vx4), .vga_y(vy4), .vga_color(vc4), .vga_plot(vp4), .busy(b4),
        .frame_done(fd4), .overrun_cnt(oc4));

    function automatic logic [2:0] col_of(input logic [7:0] cx, input logic [7:0] cy);
        return {cx[0], cy[0], cx[1]};
    endfunction

    // Renderer model: color of the coordinate seen LATENCY clocks ago
    logic [7:0] hx2 [2] = '{default: 8'd0};
    logic [7:0] hy2 [2] = '{default: 8'd0};
    logic [7:0] hx4 [4] = '{default: 8'd0};
    logic [7:0] hy4 [4] = '{default: 8'd0};
    always @(posedge clk) begin
        hx2[0] <= x2; hy2[0] <= y2; hx2[1] <= hx2[0]; hy2[1] <= hy2[0];
        hx4[0] <= x4; hy4[0] <= y4;
        for (int i = 1; i < 4; i++) begin
            hx4[i] <= hx4[i-1];
            hy4[i] <= hy4[i-1];
        end
    end
    assign c2 = col_of(hx2[1], hy2[1]);
    assign c4 = col_of(hx4[3], hy4[3]);

    logic [7:0] m_x [2], m_y [2], m_vx [2], m_vy [2];
    logic [2:0] m_vc [2];
    logic       m_plot [2], m_busy [2], m_done [2];
    assign m_x[0] = x2;   assign m_x[1] = x4;
    assign m_y[0] = y2;   assign m_y[1] = y4;
    assign m_vx[0] = vx2; assign m_vx[1] = vx4;
    assign m_vy[0] = vy2; assign m_vy[1] = vy4;
    assign m_vc[0] = vc2; assign m_vc[1] = vc4;
    assign m_plot[0] = vp2; assign m_plot[1] = vp4;
    assign m_busy[0] = b2;  assign m_busy[1] = b4;
    assign m_done[0] = fd2; assign m_done[1] = fd4;

    int plot_cnt [2], color_bad [2], order_bad [2], first_plot [2], last_plot [2];
    int first_issue [2], last_issue [2], done_cnt [2], first_done [2], done_cyc [2];
    int busy_cyc [2], start_cnt [2], last_start [2], wrap_issue [2], wrap_plot [2];
    logic [15:0] first_xy [2], last_xy [2], after_issue [2];
    logic [16:0] after_plot [2];
    logic prev_busy [2], prev_iw [2], prev_pw [2];
    int mon_idx;

    // Scoreboard: k-th plot of a frame must be raster pixel k with its model color
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (clr) begin
                plot_cnt[d] = 0; color_bad[d] = 0; order_bad[d] = 0; first_plot[d] = -1;
                last_plot[d] = -1; first_issue[d] = -1; last_issue[d] = -1; done_cnt[d] = 0;
                first_done[d] = -1; done_cyc[d] = -1; busy_cyc[d] = 0; start_cnt[d] = 0;
                last_start[d] = -1; wrap_issue[d] = -1; wrap_plot[d] = -1;
                first_xy[d] = '0; last_xy[d] = '0; after_issue[d] = '1; after_plot[d] = '1;
                prev_iw[d] = 1'b0; prev_pw[d] = 1'b0;
            end else begin
                if (m_plot[d]) begin
                    mon_idx = plot_cnt[d] % 19200;
                    if (m_vx[d] !== 8'(mon_idx % 160) || m_vy[d] !== 8'(mon_idx / 160))
                        order_bad[d]++;
                    if (m_vc[d] !== col_of(m_vx[d], m_vy[d])) color_bad[d]++;
                    if (first_plot[d] < 0) begin
                        first_plot[d] = cyc;
                        first_xy[d] = {m_vx[d], m_vy[d]};
                    end
                    last_plot[d] = cyc;
                    last_xy[d] = {m_vx[d], m_vy[d]};
                    plot_cnt[d]++;
                end
                if (m_busy[d]) busy_cyc[d]++;
                if (m_busy[d] && !prev_busy[d]) begin
                    start_cnt[d]++;
                    last_start[d] = cyc;
                    if (first_issue[d] < 0) first_issue[d] = cyc;
                end
                if (m_busy[d] && m_x[d] == 8'd159 && m_y[d] == 8'd119) last_issue[d] = cyc;
                if (m_done[d]) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                    if (first_done[d] < 0) first_done[d] = cyc;
                end
                if (prev_iw[d]) after_issue[d] = {m_x[d], m_y[d]};
                prev_iw[d] = m_busy[d] && wrap_issue[d] < 0 && m_x[d] == 8'd159 && m_y[d] == 8'd0;
                if (prev_iw[d]) wrap_issue[d] = cyc;
                if (prev_pw[d]) after_plot[d] = {m_plot[d], m_vx[d], m_vy[d]};
                prev_pw[d] = m_plot[d] && wrap_plot[d] < 0 && m_vx[d] == 8'd159 && m_vy[d] == 8'd0;
                if (prev_pw[d]) wrap_plot[d] = cyc;
            end
            prev_busy[d] = m_busy[d];
        end
    end

    task automatic clear_stats();
        clr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_frame();
        frameClk = 1'b1;
        repeat ($urandom_range(6, 3)) @(negedge clk);
        frameClk = 1'b0;
        repeat ($urandom_range(6, 3)) @(negedge clk);
    endtask

    task automatic wait_done(input int d, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt[d] >= n) break;
            @(negedge clk);
        end
        checks++;
        if (done_cnt[d] < n) begin
            errors++;
            $display("FAIL wait_done_dut%0d: frame_done count %0d, required %0d", d, done_cnt[d], n);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({x2, y2, vx2, vy2, vc2, vp2, b2, fd2, oc2, x4, y4, vx4, vy4, vc4, vp4, b4, fd4, oc4} !== '0) begin
            errors++;
            $display("FAIL reset_initial: outputs %h, required 0",
                     {x2, y2, vx2, vy2, vc2, vp2, b2, fd2, oc2});
        end
        @(negedge clk);
        resetn = 1'b1;
        pulse_frame();
        repeat ($urandom_range(600, 200)) @(negedge clk);
        checks++;
        if ({b2, vp2} !== 2'b11) begin
            errors++;
            $display("FAIL reset_precondition: busy/plot %b, required 11", {b2, vp2});
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({x2, y2, vx2, vy2, vc2, vp2, b2, fd2, oc2, x4, y4, vx4, vy4, vc4, vp4, b4, fd4, oc4} !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs %h, required 0", {x2, y2, vx2, vy2, vc2, vp2, b2, fd2, oc2});
        end
        @(negedge clk);
        resetn = 1'b1;
        clear_stats();
        repeat (100) @(negedge clk);
        checks++;
        if (plot_cnt[0] + plot_cnt[1] + busy_cyc[0] + busy_cyc[1] != 0) begin
            errors++;
            $display("FAIL reset_idle: plots %0d busy cycles %0d, required 0 and 0",
                     plot_cnt[0] + plot_cnt[1], busy_cyc[0] + busy_cyc[1]);
        end
    endtask

    task automatic test_single_frame();
        int got [9];
        int want [9];
        string nm [9];
        clear_stats();
        pulse_frame();
        wait_done(0, 1, 25000);
        wait_done(1, 1, 100);
        repeat (10) @(negedge clk);
        nm[0] = "plot_count";      got[0] = plot_cnt[0];           want[0] = 19200;
        nm[1] = "first_plot_xy";   got[1] = int'(first_xy[0]);     want[1] = 0;
        nm[2] = "last_plot_xy";    got[2] = int'(last_xy[0]);      want[2] = 159 * 256 + 119;
        nm[3] = "order_errors";    got[3] = order_bad[0];          want[3] = 0;
        nm[4] = "color_errors";    got[4] = color_bad[0];          want[4] = 0;
        nm[5] = "frame_done_cnt";  got[5] = done_cnt[0];           want[5] = 1;
        nm[6] = "done_after_last"; got[6] = done_cyc[0] - last_issue[0]; want[6] = 3;
        nm[7] = "first_plot_lat";  got[7] = first_plot[0] - first_issue[0]; want[7] = 3;
        nm[8] = "plot_span";       got[8] = last_plot[0] - first_plot[0] + 1; want[8] = 19200;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL single_%s: got %0d, required %0d", nm[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_latency4();
        int got [7];
        int want [7];
        string nm [7];
        nm[0] = "plot_count";      got[0] = plot_cnt[1];           want[0] = 19200;
        nm[1] = "first_plot_xy";   got[1] = int'(first_xy[1]);     want[1] = 0;
        nm[2] = "last_plot_xy";    got[2] = int'(last_xy[1]);      want[2] = 159 * 256 + 119;
        nm[3] = "order_errors";    got[3] = order_bad[1];          want[3] = 0;
        nm[4] = "color_errors";    got[4] = color_bad[1];          want[4] = 0;
        nm[5] = "done_after_last"; got[5] = done_cyc[1] - last_issue[1]; want[5] = 5;
        nm[6] = "first_plot_lat";  got[6] = first_plot[1] - first_issue[1]; want[6] = 5;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL lat4_%s: got %0d, required %0d", nm[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_row_wrap();
        int got [6];
        int want [6];
        for (int d = 0; d < 2; d++) begin
            got[3*d]   = int'(after_issue[d]);         want[3*d]   = 1;
            got[3*d+1] = int'(after_plot[d]);          want[3*d+1] = 65537;
            got[3*d+2] = wrap_plot[d] - wrap_issue[d]; want[3*d+2] = (d == 0) ? 3 : 5;
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL row_wrap_%0d: got %0d, required %0d", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int got [8];
        int want [8];
        clear_stats();
        repeat (3) pulse_frame();
        checks++;
        if (oc2 !== 8'd1) begin
            errors++;
            $display("FAIL overrun_one: got %0d, required 1", oc2);
        end
        repeat (300) pulse_frame();
        checks++;
        if ({oc2, oc4} !== {8'd255, 8'd255}) begin
            errors++;
            $display("FAIL overrun_saturate: got %0d/%0d, required 255", oc2, oc4);
        end
        wait_done(0, 2, 45000);
        repeat (40) @(negedge clk);
        got[0] = start_cnt[0];                  want[0] = 2;
        got[1] = last_start[0] - first_done[0]; want[1] = 2;
        got[2] = plot_cnt[0];                   want[2] = 38400;
        got[3] = order_bad[0];                  want[3] = 0;
        got[4] = color_bad[0];                  want[4] = 0;
        got[5] = done_cnt[0];                   want[5] = 2;
        got[6] = int'(b2);                      want[6] = 0;
        got[7] = int'(oc2);                     want[7] = 255;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL overrun_%0d: got %0d, required %0d", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int found = 0;
        int got [6];
        int want [6];
        clear_stats();
        pulse_frame();
        pulse_frame();
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (x2 == 8'd80 && y2 == 8'd60) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found != 1) begin
            errors++;
            $display("FAIL midreset_reach: pixel (80,60) found %0d, required 1", found);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({vp2, b2, fd2, x2, y2} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got %h, required 0", {vp2, b2, fd2, x2, y2});
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        clear_stats();
        repeat (200) @(negedge clk);
        got[0] = plot_cnt[0] + busy_cyc[0]; want[0] = 0;
        pulse_frame();
        wait_done(0, 1, 25000);
        repeat (10) @(negedge clk);
        got[1] = plot_cnt[0];        want[1] = 19200;
        got[2] = int'(first_xy[0]);  want[2] = 0;
        got[3] = order_bad[0];       want[3] = 0;
        got[4] = color_bad[0];       want[4] = 0;
        got[5] = done_cnt[0];        want[5] = 1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL midreset_%0d: got %0d, required %0d", i, got[i], want[i]);
            end
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        frameClk = 1'b0;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single_frame();
        test_latency4();
        test_row_wrap();
        test_overrun();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
